// File: rtl/conv_window_gen.sv
// Streaming P_ROWS x P_COLS sliding-window generator with runtime line length and line buffers.
// Optional eol_out port is built when CONV_WIN_EOL_OUT_EN is defined.
module conv_window_gen #(
  parameter int unsigned P_DATA_BITS   = 8,
  parameter int unsigned P_ROWS        = 3,
  parameter int unsigned P_COLS        = 3,
  parameter int unsigned P_CHANNELS    = 1,
  parameter int unsigned P_MAX_LINE    = 640,
  parameter int unsigned P_LINE_W_BITS = 10
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic [P_LINE_W_BITS-1:0]                          cfg_line_len,
  input  logic [P_CHANNELS*P_DATA_BITS-1:0]                 data_in,
  input  logic                                              valid_in,
  input  logic                                              sof_in,
  output logic                                              busy_out,
  output logic [P_CHANNELS*P_ROWS*P_COLS*P_DATA_BITS-1:0]   data_out,
  output logic                                              valid_out,
  output logic                                              sof_out,
`ifdef CONV_WIN_EOL_OUT_EN
  output logic                                              eol_out,
`endif
  input  logic                                              busy_in
);

  localparam int unsigned NumBufs = P_ROWS - 1;
  localparam int unsigned RowW    = $clog2(P_ROWS);
  localparam int unsigned LenW    = P_LINE_W_BITS + 1;
  localparam int unsigned WinW    = P_CHANNELS * P_ROWS * P_COLS * P_DATA_BITS;

  localparam logic [LenW-1:0] MaxLen      = LenW'(P_MAX_LINE);
  localparam logic [LenW-1:0] ColFirstWin = LenW'(P_COLS - 1);
  localparam logic [RowW-1:0] RowLast     = RowW'(P_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e                   state_q, state_d;
  logic [RowW-1:0]          row_cnt_q, row_cnt_d;
  logic [P_LINE_W_BITS-1:0] col_cnt_q, col_cnt_d;
  logic [LenW-1:0]          line_len_q, line_len_d;
  logic                     first_q, first_d;
  logic [WinW-1:0]          win_q, win_d;
  logic [WinW-1:0]          data_out_q, data_out_d;
  logic                     valid_out_q, valid_out_d;
  logic                     sof_out_q, sof_out_d;

  logic [P_DATA_BITS-1:0]   lbuf_q  [P_CHANNELS][NumBufs][P_MAX_LINE];
  logic [P_DATA_BITS-1:0]   lbuf_rd [P_CHANNELS][NumBufs];

  logic                     accept, produce, last_col;
  logic [LenW-1:0]          cfg_len, cur_len;
  logic [P_LINE_W_BITS-1:0] cur_col;
  logic [RowW-1:0]          cur_row;

  assign busy_out = valid_out_q & busy_in;
  assign accept   = valid_in & ~busy_out;

  // A sof beat is treated as col 0 / row 0 with the freshly sampled line length.
  always_comb begin
    cfg_len = {1'b0, cfg_line_len};
    if (cfg_len == '0 || cfg_len > MaxLen) cfg_len = MaxLen;
    cur_len  = sof_in ? cfg_len : line_len_q;
    cur_col  = sof_in ? '0 : col_cnt_q;
    cur_row  = sof_in ? '0 : row_cnt_q;
    last_col = ({1'b0, cur_col} == cur_len - LenW'(1));
    produce  = accept & ~sof_in & (state_q == StRun) & ({1'b0, col_cnt_q} >= ColFirstWin);
  end

  always_comb begin
    for (int unsigned ch = 0; ch < P_CHANNELS; ch++) begin
      for (int unsigned k = 0; k < NumBufs; k++) begin
        lbuf_rd[ch][k] = lbuf_q[ch][k][cur_col];
      end
    end
  end

  // Window shifts left by one column; the new column is oldest line first at r = 0.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned ch = 0; ch < P_CHANNELS; ch++) begin
        for (int unsigned r = 0; r < P_ROWS; r++) begin
          for (int unsigned c = 0; c < P_COLS; c++) begin
            if (c + 1 < P_COLS) begin
              win_d[((ch*P_ROWS+r)*P_COLS+c)*P_DATA_BITS +: P_DATA_BITS] =
                  win_q[((ch*P_ROWS+r)*P_COLS+c+1)*P_DATA_BITS +: P_DATA_BITS];
            end else if (r == P_ROWS - 1) begin
              win_d[((ch*P_ROWS+r)*P_COLS+c)*P_DATA_BITS +: P_DATA_BITS] =
                  data_in[ch*P_DATA_BITS +: P_DATA_BITS];
            end else begin
              win_d[((ch*P_ROWS+r)*P_COLS+c)*P_DATA_BITS +: P_DATA_BITS] =
                  lbuf_rd[ch][P_ROWS-2-r];
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    line_len_d = line_len_q;
    first_d    = first_q;
    if (accept && (sof_in || state_q != StIdle)) begin
      line_len_d = cur_len;
      if (last_col) begin
        col_cnt_d = '0;
        row_cnt_d = (cur_row == RowLast) ? cur_row : cur_row + RowW'(1);
      end else begin
        col_cnt_d = cur_col + P_LINE_W_BITS'(1);
        row_cnt_d = cur_row;
      end
      state_d = (row_cnt_d == RowLast) ? StRun : StFill;
      if (sof_in) begin
        first_d = 1'b1;
      end else if (produce) begin
        first_d = 1'b0;
      end
    end
  end

  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    sof_out_d   = sof_out_q;
    if (produce) begin
      data_out_d  = win_d;
      valid_out_d = 1'b1;
      sof_out_d   = first_q;
    end else if (valid_out_q & ~busy_in) begin
      valid_out_d = 1'b0;
      sof_out_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      line_len_q  <= MaxLen;
      first_q     <= 1'b0;
      win_q       <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      line_len_q  <= line_len_d;
      first_q     <= first_d;
      win_q       <= win_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
    end
  end

  // Line buffers are not reset; a new frame re-primes them before any window uses them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int unsigned ch = 0; ch < P_CHANNELS; ch++) begin
        lbuf_q[ch][0][cur_col] <= data_in[ch*P_DATA_BITS +: P_DATA_BITS];
        for (int unsigned k = 1; k < NumBufs; k++) begin
          lbuf_q[ch][k][cur_col] <= lbuf_rd[ch][k-1];
        end
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;

`ifdef CONV_WIN_EOL_OUT_EN
  logic eol_q, eol_d;

  always_comb begin
    eol_d = eol_q;
    if (produce) begin
      eol_d = last_col;
    end else if (valid_out_q & ~busy_in) begin
      eol_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      eol_q <= 1'b0;
    end else begin
      eol_q <= eol_d;
    end
  end

  assign eol_out = eol_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised and directed bench for conv_window_gen against a pixel-index reference model.
// Checks eol_out too when CONV_WIN_EOL_OUT_EN is defined.
module tb_conv_window_gen;

  localparam int R    = 3;
  localparam int C    = 3;
  localparam int CH   = 2;
  localparam int DB   = 8;
  localparam int MAXL = 640;
  localparam int LW   = 10;
  localparam int WB   = CH * R * C * DB;
  localparam int MAXN = 2048;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [LW-1:0] cfg_line_len = '0;
  logic [CH*DB-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          sof_in = 1'b0;
  logic          busy_in = 1'b0;
  logic          busy_out, valid_out, sof_out;
  logic [WB-1:0] data_out;
`ifdef CONV_WIN_EOL_OUT_EN
  logic          eol_out;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: frame pixels indexed by arrival order since sof.
  logic [DB-1:0] pix [CH][MAXN];
  logic          mv, msof, meol;
  logic [WB-1:0] mdata;
  bit            in_frame, first;
  int            fl, fn;

  // Observation of DUT windows
  int            win_cnt, eol_cnt, first_at, acc_since_sof;
  logic          first_sof;
  logic [WB-1:0] first_data, last_data;
  bit            rand_busy = 0;
  int            stall_req = 0;

  conv_window_gen #(
    .P_DATA_BITS  (DB),
    .P_ROWS       (R),
    .P_COLS       (C),
    .P_CHANNELS   (CH),
    .P_MAX_LINE   (MAXL),
    .P_LINE_W_BITS(LW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .cfg_line_len(cfg_line_len),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .sof_in      (sof_in),
    .busy_out    (busy_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .sof_out     (sof_out),
`ifdef CONV_WIN_EOL_OUT_EN
    .eol_out     (eol_out),
`endif
    .busy_in     (busy_in)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [WB-1:0] got,
                             input logic [WB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mv = 1'b0; msof = 1'b0; meol = 1'b0; mdata = '0;
    in_frame = 0; first = 0; fl = MAXL; fn = 0;
  endtask

  task automatic model_edge(output logic acc);
    bit prod, eolv;
    int row, col;
    logic [WB-1:0] w;
    prod = 0; eolv = 0; w = '0;
    acc = valid_in && !(mv && busy_in);
    if (acc) begin
      if (sof_in) begin
        in_frame = 1;
        fl = (cfg_line_len == 0 || int'(cfg_line_len) > MAXL) ? MAXL : int'(cfg_line_len);
        fn = 0;
        first = 1;
      end
      if (in_frame) begin
        row = fn / fl;
        col = fn % fl;
        if (fn < MAXN) begin
          for (int ch = 0; ch < CH; ch++) pix[ch][fn] = data_in[ch*DB +: DB];
        end
        if (row >= R - 1 && col >= C - 1) begin
          prod = 1;
          eolv = (col == fl - 1);
          for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < R; r++)
              for (int c = 0; c < C; c++)
                w[((ch*R+r)*C+c)*DB +: DB] = pix[ch][(row-(R-1)+r)*fl + col-(C-1)+c];
        end
        fn++;
      end
    end
    if (prod) begin
      mv = 1'b1; msof = first; first = 0; mdata = w; meol = eolv;
    end else if (mv && !busy_in) begin
      mv = 1'b0; msof = 1'b0; meol = 1'b0;
    end
  endtask

  task automatic step(input logic vi, input logic si, input int v0, input int v1,
                      input logic bi, output logic acc);
    logic pv;
    valid_in = vi;
    sof_in   = si;
    data_in  = {8'(v1), 8'(v0)};
    busy_in  = bi;
    #1;
    check_value("busy_out", WB'(busy_out), WB'(mv && bi));
    pv = valid_out;
    @(posedge i_clk);
    model_edge(acc);
    if (acc) acc_since_sof = si ? 1 : acc_since_sof + 1;
    #1;
    check_value("valid_out", WB'(valid_out), WB'(mv));
    check_value("sof_out", WB'(sof_out), WB'(msof));
    check_value("data_out", data_out, mdata);
`ifdef CONV_WIN_EOL_OUT_EN
    check_value("eol_out", WB'(eol_out), WB'(meol));
`endif
    if (valid_out && !(pv && bi)) begin
      win_cnt++;
      if (win_cnt == 1) begin
        first_at   = acc_since_sof;
        first_data = data_out;
        first_sof  = sof_out;
      end
      last_data = data_out;
`ifdef CONV_WIN_EOL_OUT_EN
      if (eol_out) eol_cnt++;
`endif
    end
  endtask

  task automatic send_pix(input bit si, input int v0, input int v1);
    logic acc, bi;
    int tries;
    acc = 1'b0;
    tries = 0;
    if (rand_busy && $urandom_range(0, 3) == 0) begin
      bi = ($urandom_range(0, 2) == 0);
      step(1'b0, 1'b0, 0, 0, bi, acc);
    end
    acc = 1'b0;
    while (!acc) begin
      if (!si && rand_busy) cfg_line_len = LW'($urandom_range(0, 20));
      if (rand_busy) begin
        bi = ($urandom_range(0, 2) == 0);
      end else if (stall_req > 0 && mv) begin
        bi = 1'b1;
        stall_req--;
      end else begin
        bi = 1'b0;
      end
      step(1'b1, si, v0, v1, bi, acc);
      tries++;
      if (!acc && tries > 200) begin
        check_value("accept_timeout", WB'(0), WB'(1));
        break;
      end
    end
  endtask

  task automatic send_frame(input int len, input int np, input bit rnd);
    int v0, v1;
    cfg_line_len = LW'(len);
    for (int i = 0; i < np; i++) begin
      v0 = rnd ? int'($urandom_range(0, 255)) : i;
      v1 = rnd ? int'($urandom_range(0, 255)) : i + 100;
      send_pix(i == 0, v0, v1);
    end
  endtask

  task automatic clear_stats();
    win_cnt = 0; eol_cnt = 0; first_at = -1; first_sof = 1'b0;
    first_data = '0; last_data = '0;
  endtask

  function automatic logic [WB-1:0] exp_win(input int base, input int len);
    logic [WB-1:0] w;
    w = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          w[((ch*R+r)*C+c)*DB +: DB] = 8'(base + r*len + c + ch*100);
    return w;
  endfunction

  initial begin
    int len, np;
    model_reset();
    clear_stats();
    acc_since_sof = 0;
    busy_in = 1'b1;
    #3;
    check_value("rst_valid_out", WB'(valid_out), WB'(0));
    check_value("rst_sof_out", WB'(sof_out), WB'(0));
    check_value("rst_data_out", data_out, '0);
    check_value("rst_busy_out", WB'(busy_out), WB'(0));
    #4;
    i_rst = 1'b0;
    busy_in = 1'b0;

    // Nominal 5x4 frame
    clear_stats();
    send_frame(5, 20, 0);
    check_value("t1_windows", WB'(win_cnt), WB'(6));
    check_value("t1_first_at", WB'(first_at), WB'(13));
    check_value("t1_first_win", first_data, exp_win(0, 5));
    check_value("t1_first_sof", WB'(first_sof), WB'(1));
    check_value("t1_last_win", last_data, exp_win(7, 5));
`ifdef CONV_WIN_EOL_OUT_EN
    check_value("t1_eol_count", WB'(eol_cnt), WB'(2));
`endif

    // Downstream stall of 4 cycles
    clear_stats();
    stall_req = 4;
    send_frame(5, 20, 0);
    check_value("t2_windows", WB'(win_cnt), WB'(6));
    check_value("t2_stall_used", WB'(stall_req), WB'(0));
    check_value("t2_first_win", first_data, exp_win(0, 5));
    check_value("t2_last_win", last_data, exp_win(7, 5));

    // Mid-frame restart at pixel 7
    send_frame(5, 7, 0);
    clear_stats();
    send_frame(5, 20, 0);
    check_value("t3_windows", WB'(win_cnt), WB'(6));
    check_value("t3_first_at", WB'(first_at), WB'(13));
    check_value("t3_first_sof", WB'(first_sof), WB'(1));

    // Line shorter than the window, then zero length meaning maximum
    clear_stats();
    send_frame(2, 12, 0);
    check_value("t4_short_windows", WB'(win_cnt), WB'(0));
    clear_stats();
    send_frame(0, 1284, 0);
    check_value("t4_max_first_at", WB'(first_at), WB'(1283));
    check_value("t4_max_windows", WB'(win_cnt), WB'(2));

    // Asynchronous reset while a window is pending
    send_frame(5, 15, 0);
    check_value("t5_pre_valid", WB'(valid_out), WB'(1));
    valid_in = 1'b0;
    i_rst = 1'b1;
    #1;
    check_value("t5_rst_valid", WB'(valid_out), WB'(0));
    check_value("t5_rst_data", data_out, '0);
    model_reset();
    #3;
    i_rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 12; i++) send_pix(1'b0, i, i + 100);
    check_value("t5_idle_windows", WB'(win_cnt), WB'(0));
    clear_stats();
    send_frame(4, 12, 0);
    check_value("t5_recover_windows", WB'(win_cnt), WB'(2));

    // Randomised frames with random stalls, gaps and truncations
    rand_busy = 1;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 12);
      if (f % 8 == 7) len = 900;
      np = $urandom_range(1, 6 * 12);
      send_frame(len, np, 1);
    end
    rand_busy = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator for the convolution datapath. It is the parametrised successor of the fixed shift-register row converter. It accepts one pixel per beat, per channel, and buffers P_ROWS-1 full lines in RAM-style line buffers, with the line length set at runtime. It emits a P_ROWS x P_COLS window per channel only when every tap holds valid pixels of the current frame. It sits between the pixel source and the MAC array.

Parameters:
P_DATA_BITS, 8, bits per pixel per channel
P_ROWS, 3, window height (>=2)
P_COLS, 3, window width (>=2)
P_CHANNELS, 1, independent channels sharing control
P_MAX_LINE, 640, line-buffer depth; maximum supported line length
P_LINE_W_BITS, 10, width of cfg_line_len and the column counter (2^P_LINE_W_BITS >= P_MAX_LINE)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
cfg_line_len  in  P_LINE_W_BITS  pixels per line; sampled on accepted sof_in
data_in  in  P_CHANNELS*P_DATA_BITS  pixel; channel c at bits [c*P_DATA_BITS +: P_DATA_BITS]
valid_in  in  1  data_in valid
sof_in  in  1  first pixel of frame; qualified by valid_in
busy_out  out  1  upstream must hold its beat
data_out  out  P_CHANNELS*P_ROWS*P_COLS*P_DATA_BITS  window; element (ch,r,c) at bits [((ch*P_ROWS+r)*P_COLS+c)*P_DATA_BITS +: P_DATA_BITS]; r=0 oldest line, c=0 oldest column
valid_out  out  1  window valid
sof_out  out  1  first window of frame
busy_in  in  1  downstream stall

Behaviour:
- Accept = valid_in & !busy_out.
- busy_out = valid_out & busy_in (combinational). A bubble collapses: when valid_out=0, input is accepted even while busy_in=1.
- Reset values: valid_out=0, sof_out=0, data_out=0, busy_out=0. State=IDLE; row_cnt=0; col_cnt=0; line_len=P_MAX_LINE.
- Line-buffer contents are not reset. FILL re-primes them.
- Reset asserted mid-frame drops any pending window immediately.
- Latency: a window completed by an accepted pixel appears on data_out on the next clock edge (1 cycle).
- Line length:
  - line_len is latched from cfg_line_len on an accepted sof_in.
  - 0 or values > P_MAX_LINE latch as P_MAX_LINE.
  - Values < P_COLS are legal; they produce no windows.
- Counters:
  - col_cnt counts 0..line_len-1, then wraps to 0 and increments row_cnt.
  - row_cnt saturates at P_ROWS-1.
  - An accepted sof_in forces the pixel to col 0, row 0, even mid-frame; the partial frame is abandoned.
- Line buffers:
  - P_ROWS-1 buffers per channel, each P_MAX_LINE deep, addressed by col_cnt.
  - Each access is read-before-write.
  - Buffer 0 writes data_in; buffer k writes the read data of buffer k-1.
  - The new window column is {buf[P_ROWS-2] read, ..., buf[0] read, data_in}, oldest line first.
- Window registers shift one column per accept. The new column enters at c=P_COLS-1; column c=0 is dropped.
- State machine:
  - IDLE: discard beats until an accepted sof_in, then go to FILL. Non-sof beats are still accepted, so busy_out stays low.
  - FILL: row_cnt < P_ROWS-1; no output. Move to RUN when row_cnt reaches P_ROWS-1.
  - RUN: a window is produced on an accept when col_cnt >= P_COLS-1, so windows never span a line boundary.
  - Accepted sof_in in FILL or RUN: go to FILL, with counters restarted.
- Output register update:
  - Window produced: load data_out and set valid_out=1.
  - sof_out=1 only for the first window after each sof_in.
  - Consumed with no new window (valid_out & !busy_in): valid_out=0 and sof_out=0; data_out holds.
  - valid_out & busy_in: all outputs hold and no accept occurs.
- Windows per frame of H lines: (H-P_ROWS+1)*(line_len-P_COLS+1).
- Channels never interact; they share all control.

Optional Feature:
Macro CONV_WIN_EOL_OUT_EN.
- Defined: adds output port eol_out (1 bit, reset 0, registered alongside valid_out with the same hold/clear rules). eol_out=1 on the window produced when col_cnt = line_len-1, i.e. the last window of a line.
- Undefined: the port does not exist and no extra logic is built. All other behaviour is identical.

Test Plan:
1. Nominal window sequence:
   - Setup: defaults, cfg_line_len=5, frame of 4 lines carrying values 0..19, busy_in=0.
   - Expect: first valid_out one cycle after accepting pixel 12, with window {0,1,2,5,6,7,10,11,12} and sof_out=1.
   - Expect: exactly 6 windows; the last is {7,8,9,12,13,14,17,18,19}.
2. Downstream stall:
   - Setup: as test 1, with busy_in=1 for 4 cycles while valid_out=1.
   - Expect: data_out stable, busy_out=1, no pixel lost; window sequence identical to test 1.
3. Mid-frame restart:
   - Setup: sof_in asserted at pixel 7 of a frame.
   - Expect: no window until 2*5+3 pixels after the restart; the first window has sof_out=1.
4. Line length 2 with P_COLS=3:
   - Expect: valid_out never asserts over a 6-line frame.
   - Then: cfg_line_len=0 latches as P_MAX_LINE=640; the first window arrives after pixel 1282.
5. Reset mid-operation:
   - Setup: assert i_rst asynchronously while valid_out=1.
   - Expect: valid_out=0 immediately. Non-sof pixels are accepted but produce no windows until the next sof_in.
6. Channel independence and EOL:
   - Setup: P_CHANNELS=2, second channel fed value+100, CONV_WIN_EOL_OUT_EN defined.
   - Expect: channel 1 window = channel 0 window +100, elementwise.
   - Expect: eol_out=1 on every third window when line_len=5.
